// File: rtl/dm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dm_pipe
// Brief    : Word-organised little-endian data memory with req/ready handshake,
//            configurable read latency, byte/half/word access and post-reset clear.
// Revision : 1.0
// ============================================================================
module dm_pipe #(
    parameter int ADDR_W         = 12,
    parameter int LATENCY        = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        fault
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);
    localparam int IDX_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam state_t           c_reset_state = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
    localparam logic [IDX_W-1:0] c_last_idx    = IDX_W'(DEPTH - 1);
    localparam logic [1:0]       c_wait_init   = 2'(LATENCY - 1);

    logic [31:0]      r_mem [0:DEPTH-1];
    state_t           r_state;
    logic [IDX_W-1:0] r_clr_cnt;
    logic [1:0]       r_wcnt;
    logic             r_ready;
    logic             r_rvalid;
    logic [31:0]      r_rdata;
    logic             r_fault;
    logic [31:0]      r_pdata;
    logic             r_pfault;

    logic             w_accept;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_word;
    logic [4:0]       w_shift;
    logic [31:0]      w_lane;
    logic             w_fault;
    logic             w_store;
    logic [31:0]      w_load;
    logic [31:0]      w_result;
    logic [3:0]       w_be;
    logic [31:0]      w_wlane;

    assign w_accept = req && r_ready;
    assign w_idx    = addr[ADDR_W-1:2];
    assign w_word   = r_mem[w_idx];
    assign w_shift  = {addr[1:0], 3'b000};
    assign w_lane   = w_word >> w_shift;

    assign w_fault  = (size == 2'd3)
                   || ((size == 2'd1) && addr[0])
                   || ((size == 2'd2) && (addr[1:0] != 2'd0))
                   || ((addr >> ADDR_W) != 32'd0);
    assign w_store  = w_accept && we && !w_fault;

    // Stores and faults always answer with zero data.
    assign w_result = (we || w_fault) ? 32'd0 : w_load;

    always_comb begin
        w_load = w_lane;
        case (size)
            2'd0:    w_load = {{24{sign_ext & w_lane[7]}},  w_lane[7:0]};
            2'd1:    w_load = {{16{sign_ext & w_lane[15]}}, w_lane[15:0]};
            default: w_load = w_lane;
        endcase
    end

    always_comb begin
        w_be    = 4'b0000;
        w_wlane = 32'd0;
        case (size)
            2'd0: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wlane = {24'd0, wdata[7:0]} << w_shift;
            end
            2'd1: begin
                w_be    = 4'b0011 << addr[1:0];
                w_wlane = {16'd0, wdata[15:0]} << w_shift;
            end
            default: begin
                w_be    = 4'b1111;
                w_wlane = wdata;
            end
        endcase
    end

    // Storage has no reset; only the clear sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_cnt] <= 32'd0;
        end else if (w_store) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (w_store) begin
            $display("@%h: *%h <= %h", pc, addr, wdata);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_reset_state;
            r_clr_cnt <= '0;
            r_wcnt    <= 2'd0;
            r_ready   <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
            r_fault   <= 1'b0;
            r_pdata   <= 32'd0;
            r_pfault  <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + IDX_W'(1);
                    if (r_clr_cnt == c_last_idx) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_wcnt == 2'd1) begin
                        r_state  <= S_RESP;
                        r_ready  <= 1'b1;
                        r_rvalid <= 1'b1;
                        r_rdata  <= r_pdata;
                        r_fault  <= r_pfault;
                    end else begin
                        r_wcnt <= r_wcnt - 2'd1;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        if (LATENCY == 1) begin
                            r_state  <= S_RESP;
                            r_rvalid <= 1'b1;
                            r_rdata  <= w_result;
                            r_fault  <= w_fault;
                        end else begin
                            r_state  <= S_WAIT;
                            r_ready  <= 1'b0;
                            r_wcnt   <= c_wait_init;
                            r_pdata  <= w_result;
                            r_pfault <= w_fault;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign ready  = r_ready;
    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;
    assign fault  = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_dm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_pipe
// Brief    : Directed self-checking bench for dm_pipe (latency 1 and latency 3).
// Revision : 1.0
// ============================================================================
module tb_dm_pipe;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, reset_b, req_a, req_b;
    logic        we, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata, pc;
    logic        ready_a, rvalid_a, fault_a;
    logic        ready_b, rvalid_b, fault_b;
    logic [31:0] rdata_a, rdata_b;

    int tests  = 0;
    int failed = 0;

    dm_pipe #(.ADDR_W(12), .LATENCY(1), .CLEAR_ON_RESET(1'b1)) u_a (
        .clk(clk), .reset(reset_a), .req(req_a), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .pc(pc),
        .ready(ready_a), .rvalid(rvalid_a), .rdata(rdata_a), .fault(fault_a)
    );

    dm_pipe #(.ADDR_W(8), .LATENCY(3), .CLEAR_ON_RESET(1'b1)) u_b (
        .clk(clk), .reset(reset_b), .req(req_b), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .pc(pc),
        .ready(ready_b), .rvalid(rvalid_b), .rdata(rdata_b), .fault(fault_b)
    );

    // One complete transaction; returns response, accept-to-rvalid latency
    // and rvalid one cycle after the response.
    task automatic do_req(input bit sel, input logic w, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic ft, output int lat,
                          output logic rv_after);
        int n;
        we = w; size = sz; sign_ext = sx; addr = a; wdata = d; pc = 32'h0000_0400 + a;
        n = 0;
        while (!(sel ? ready_b : ready_a) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0;
        lat = 1;
        while (!(sel ? rvalid_b : rvalid_a) && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        rd = sel ? rdata_b : rdata_a;
        ft = sel ? fault_b : fault_a;
        @(posedge clk); #1;
        rv_after = sel ? rvalid_b : rvalid_a;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic ft, rva; int lat, cnt;
        tests++;
        if ({ready_a, rvalid_a, fault_a, rdata_a} !== 35'd0) begin
            failed++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b ft=%b rd=%h, want all 0",
                     ready_a, rvalid_a, fault_a, rdata_a);
        end
        reset_a = 1'b1;
        cnt = 0;
        while (!ready_a && cnt < 3000) begin
            cnt++; @(posedge clk); #1;
        end
        tests++;
        if (cnt != 1024) begin
            failed++; $display("FAIL clear_duration: got %0d, want 1024", cnt);
        end
        do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, ft, lat, rva);
        tests++;
        if ({ft, rd} !== 33'd0) begin
            failed++; $display("FAIL lw0_after_clear: got ft=%b rd=%h, want ft=0 rd=0", ft, rd);
        end
        tests++;
        if (lat != 1 || rva !== 1'b0) begin
            failed++; $display("FAIL lw0_timing: got lat=%0d rv_after=%b, want lat=1 rv_after=0", lat, rva);
        end
    endtask

    task automatic test_store_load();
        logic [1:0]  sz[7]  = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
        logic        sx[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        w[7]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] a[7]   = '{32'h10, 32'h13, 32'h12, 32'h10, 32'h12, 32'h12, 32'h10};
        logic [31:0] exp[7] = '{32'h0, 32'hFFFF_FF80, 32'h0000_00FF, 32'h0000_1234,
                                32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_1234};
        logic [31:0] rd; logic ft, rva; int lat;
        for (int i = 0; i < 7; i++) begin
            do_req(1'b0, w[i], sz[i], sx[i], a[i], 32'h80FF_1234, rd, ft, lat, rva);
            tests++;
            if ({ft, rd} !== {1'b0, exp[i]}) begin
                failed++;
                $display("FAIL store_load[%0d]: got ft=%b rd=%h, want ft=0 rd=%h", i, ft, rd, exp[i]);
            end
        end
    endtask

    task automatic test_byte_lane();
        logic [1:0]  sz[5]  = '{2'd2, 2'd0, 2'd2, 2'd1, 2'd2};
        logic        w[5]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] a[5]   = '{32'h20, 32'h21, 32'h20, 32'h22, 32'h20};
        logic [31:0] d[5]   = '{32'h0, 32'h1234_56AB, 32'h0, 32'h7777_BEEF, 32'h0};
        logic [31:0] exp[5] = '{32'h0, 32'h0, 32'h0000_AB00, 32'h0, 32'hBEEF_AB00};
        logic [31:0] rd; logic ft, rva; int lat;
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, w[i], sz[i], 1'b0, a[i], d[i], rd, ft, lat, rva);
            if (!w[i]) begin
                tests++;
                if ({ft, rd} !== {1'b0, exp[i]}) begin
                    failed++;
                    $display("FAIL byte_lane[%0d]: got ft=%b rd=%h, want ft=0 rd=%h", i, ft, rd, exp[i]);
                end
            end
        end
    endtask

    task automatic test_faults();
        logic [1:0]  sz[6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 2'd2};
        logic        w[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] a[6]  = '{32'h11, 32'h22, 32'h10, 32'h1000, 32'h1010, 32'h12};
        logic [31:0] d[6]  = '{32'hFFFF, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0};
        logic [31:0] rd; logic ft, rva; int lat;
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, w[i], sz[i], 1'b1, a[i], d[i], rd, ft, lat, rva);
            tests++;
            if ({ft, rd} !== {1'b1, 32'h0} || lat != 1) begin
                failed++;
                $display("FAIL fault[%0d]: got ft=%b rd=%h lat=%0d, want ft=1 rd=0 lat=1", i, ft, rd, lat);
            end
        end
        do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, ft, lat, rva);
        tests++;
        if ({ft, rd} !== {1'b0, 32'h80FF_1234}) begin
            failed++; $display("FAIL fault_nowrite_10: got ft=%b rd=%h, want ft=0 rd=80ff1234", ft, rd);
        end
        do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, ft, lat, rva);
        tests++;
        if ({ft, rd} !== {1'b0, 32'hBEEF_AB00}) begin
            failed++; $display("FAIL fault_nowrite_20: got ft=%b rd=%h, want ft=0 rd=beefab00", ft, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic        w[3]   = '{1'b1, 1'b0, 1'b0};
        logic [1:0]  sz[3]  = '{2'd2, 2'd2, 2'd0};
        logic [31:0] a[3]   = '{32'h8, 32'h8, 32'h9};
        logic [31:0] exp[3] = '{32'h0, 32'hCAFE_F00D, 32'hFFFF_FFF0};
        logic [31:0] resp[3];
        logic [2:0]  fts;
        logic [10:0] rdy, rv, acc;
        int k, r, n;
        reset_b = 1'b1;
        n = 0;
        while (!ready_b && n < 500) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (ready_b !== 1'b1) begin
            failed++; $display("FAIL b_clear_done: got ready=%b, want 1", ready_b);
        end
        k = 0; r = 0; fts = 3'd0;
        for (int i = 0; i < 3; i++) resp[i] = 32'hx;
        for (int c = 0; c < 11; c++) begin
            rdy[c] = ready_b;
            rv[c]  = rvalid_b;
            if (rvalid_b && r < 3) begin
                resp[r] = rdata_b; fts[r] = fault_b; r++;
            end
            if (k < 3) begin
                we = w[k]; size = sz[k]; sign_ext = 1'b1; addr = a[k];
                wdata = 32'hCAFE_F00D; pc = 32'h0000_0200 + 32'(k);
                req_b = 1'b1;
            end else begin
                req_b = 1'b0;
            end
            acc[c] = req_b && ready_b;
            if (acc[c]) k++;
            @(posedge clk); #1;
        end
        req_b = 1'b0;
        tests++;
        if (acc !== 11'h049) begin
            failed++; $display("FAIL b2b_accepts: got %b, want %b", acc, 11'h049);
        end
        tests++;
        if (rv !== 11'h248) begin
            failed++; $display("FAIL b2b_rvalid: got %b, want %b", rv, 11'h248);
        end
        tests++;
        if (rdy !== 11'h649) begin
            failed++; $display("FAIL b2b_ready: got %b, want %b", rdy, 11'h649);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (resp[i] !== exp[i]) begin
                failed++; $display("FAIL b2b_rdata[%0d]: got %h, want %h", i, resp[i], exp[i]);
            end
        end
        tests++;
        if (fts !== 3'd0) begin
            failed++; $display("FAIL b2b_faults: got %b, want 000", fts);
        end
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd; logic ft, rva, seen; int lat, cnt;
        we = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'h8; wdata = 32'h0;
        req_b = 1'b1;
        @(posedge clk); #1;
        req_b = 1'b0;
        tests++;
        if ({ready_b, rvalid_b} !== 2'b00) begin
            failed++; $display("FAIL wait_entry: got rdy=%b rv=%b, want 0 0", ready_b, rvalid_b);
        end
        reset_b = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if ({ready_b, rvalid_b, fault_b, rdata_b} !== 35'd0) begin
            failed++;
            $display("FAIL reset_in_wait: got rdy=%b rv=%b ft=%b rd=%h, want all 0",
                     ready_b, rvalid_b, fault_b, rdata_b);
        end
        reset_b = 1'b1;
        cnt = 0; seen = 1'b0;
        while (!ready_b && cnt < 500) begin
            if (rvalid_b) seen = 1'b1;
            cnt++; @(posedge clk); #1;
        end
        tests++;
        if (cnt != 64 || seen !== 1'b0) begin
            failed++; $display("FAIL dropped_req: got clear=%0d rv_seen=%b, want 64 0", cnt, seen);
        end
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rd, ft, lat, rva);
        tests++;
        if ({ft, rd} !== 33'd0 || lat != 3 || rva !== 1'b0) begin
            failed++;
            $display("FAIL b_lw_after_clear: got ft=%b rd=%h lat=%0d rv_after=%b, want 0 0 3 0",
                     ft, rd, lat, rva);
        end
        do_req(1'b1, 1'b1, 2'd2, 1'b0, 32'h4, 32'h1122_3344, rd, ft, lat, rva);
        reset_b = 1'b0;
        @(posedge clk); #1;
        reset_b = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        reset_b = 1'b0;
        @(posedge clk); #1;
        reset_b = 1'b1;
        cnt = 0;
        while (!ready_b && cnt < 500) begin
            cnt++; @(posedge clk); #1;
        end
        tests++;
        if (cnt != 64) begin
            failed++; $display("FAIL mid_clear_restart: got %0d, want 64", cnt);
        end
        do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, rd, ft, lat, rva);
        tests++;
        if ({ft, rd} !== 33'd0) begin
            failed++; $display("FAIL b_word4_cleared: got ft=%b rd=%h, want ft=0 rd=0", ft, rd);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_a = 1'b1; reset_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
        we = 1'b0; size = 2'd0; sign_ext = 1'b0; addr = 32'h0; wdata = 32'h0; pc = 32'h0;
        #3;
        reset_a = 1'b0; reset_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_store_load();
        test_byte_lane();
        test_faults();
        test_back_to_back();
        test_reset_wait();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
